// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared 640x480@60 raster constants and types
package vga_pkg;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;

    localparam int VGA_H_TOTAL = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
    localparam int VGA_V_TOTAL = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

    localparam int COORD_W  = 10;
    localparam int RGB888_W = 24;

    typedef logic [RGB888_W-1:0] rgb888_t;

    typedef enum logic {
        WAIT_LOCK = 1'b0,
        RUN       = 1'b1
    } vga_state_t;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop single-bit synchroniser with asynchronous reset
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic meta_d;
    logic sync_q;
    logic sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster timing generator with show-ahead FIFO pixel fetch
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP,
    parameter bit SYNC_POL = 1'b0,
    parameter int RGB_W    = RGB888_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pll_locked,
    input  logic [RGB_W-1:0]   pix_data,
    input  logic               pix_empty,
    output logic               pix_rd,
    output logic               hsync,
    output logic               vsync,
    output logic               de,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic [RGB_W-1:0]   rgb,
    output logic               frame_start,
    output logic               underflow,
    input  logic               underflow_clr
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [COORD_W-1:0] H_LAST = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] V_LAST = COORD_W'(V_TOTAL - 1);
    localparam logic [COORD_W-1:0] H_ACT  = COORD_W'(H_ACTIVE);
    localparam logic [COORD_W-1:0] V_ACT  = COORD_W'(V_ACTIVE);
    localparam logic [COORD_W-1:0] HS_BEG = COORD_W'(H_ACTIVE + H_FP);
    localparam logic [COORD_W-1:0] HS_END = COORD_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [COORD_W-1:0] VS_BEG = COORD_W'(V_ACTIVE + V_FP);
    localparam logic [COORD_W-1:0] VS_END = COORD_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic SYNC_ON  = SYNC_POL;
    localparam logic SYNC_OFF = ~SYNC_POL;

    logic lock_s;
    vga_state_t state_q, state_d;
    logic [COORD_W-1:0] h_q, h_d, v_q, v_d;
    logic run0, act0, hs0, vs0;

    logic hsync_q, hsync_d, vsync_q, vsync_d, de_q, de_d;
    logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
    logic [RGB_W-1:0] rgb_q, rgb_d;
    logic frame_start_q, frame_start_d, underflow_q, underflow_d;

    sync_2ff u_lock_sync (
        .clk (clk),
        .rst (rst),
        .d   (pll_locked),
        .q   (lock_s)
    );

    always_comb begin
        state_d = state_q;
        h_d     = '0;
        v_d     = '0;
        case (state_q)
            WAIT_LOCK: begin
                if (lock_s) state_d = RUN;
            end
            RUN: begin
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                end else if (h_q == H_LAST) begin
                    v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
                end else begin
                    h_d = h_q + 1'b1;
                    v_d = v_q;
                end
            end
        endcase
    end

    // Qualifying with lock_s stops popping as soon as lock is seen gone, so the
    // edge that drops back to WAIT_LOCK also loads idle values into stage 1.
    assign run0   = (state_q == RUN) && lock_s;
    assign act0   = run0 && (h_q < H_ACT) && (v_q < V_ACT);
    assign hs0    = (h_q >= HS_BEG) && (h_q < HS_END);
    assign vs0    = (v_q >= VS_BEG) && (v_q < VS_END);
    assign pix_rd = act0 && !pix_empty;

    always_comb begin
        hsync_d       = (run0 && hs0) ? SYNC_ON : SYNC_OFF;
        vsync_d       = (run0 && vs0) ? SYNC_ON : SYNC_OFF;
        de_d          = act0;
        x_d           = run0 ? h_q : '0;
        y_d           = run0 ? v_q : '0;
        rgb_d         = pix_rd ? pix_data : '0;
        frame_start_d = run0 && (h_q == '0) && (v_q == '0);
        underflow_d   = underflow_q;
        if (act0 && pix_empty) begin
            underflow_d = 1'b1;
        end else if (underflow_clr) begin
            underflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= WAIT_LOCK;
            h_q           <= '0;
            v_q           <= '0;
            hsync_q       <= SYNC_OFF;
            vsync_q       <= SYNC_OFF;
            de_q          <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            rgb_q         <= '0;
            frame_start_q <= 1'b0;
            underflow_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            h_q           <= h_d;
            v_q           <= v_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            de_q          <= de_d;
            x_q           <= x_d;
            y_q           <= y_d;
            rgb_q         <= rgb_d;
            frame_start_q <= frame_start_d;
            underflow_q   <= underflow_d;
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign de          = de_q;
    assign x           = x_q;
    assign y           = y_q;
    assign rgb         = rgb_q;
    assign frame_start = frame_start_q;
    assign underflow   = underflow_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - self-checking bench for vga_timing_gen
module tb_vga_timing_gen;
    import vga_pkg::*;

    // Full 800-clock lines with a shortened 30-line frame keeps the run short.
    localparam int HT = 800;
    localparam int HA = 640;
    localparam int VA = 20;
    localparam int VF = 3;
    localparam int VS = 2;
    localparam int VB = 5;
    localparam int VT = VA + VF + VS + VB;

    logic clk = 1'b0;
    always #20 clk = ~clk;

    logic rst, pll_locked, pix_empty, underflow_clr;
    logic pix_rd, hsync, vsync, de, frame_start, underflow;
    logic [9:0] x, y;
    logic [23:0] rgb, pix_data;

    logic rst2, lock2;
    logic pix_rd2, hsync2, vsync2, de2, fs2, uf2;
    logic [9:0] x2, y2;
    logic [23:0] rgb2;

    int checks = 0;
    int errors = 0;
    int word_idx;
    logic cmp_on = 1'b0;

    function automatic rgb888_t pixval(input int i);
        return rgb888_t'(i * 7 + 3);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    vga_timing_gen #(
        .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB)
    ) u_dut (
        .clk (clk), .rst (rst), .pll_locked (pll_locked),
        .pix_data (pix_data), .pix_empty (pix_empty), .pix_rd (pix_rd),
        .hsync (hsync), .vsync (vsync), .de (de), .x (x), .y (y), .rgb (rgb),
        .frame_start (frame_start), .underflow (underflow), .underflow_clr (underflow_clr)
    );

    vga_timing_gen #(
        .H_ACTIVE (8), .H_FP (2), .H_SYNC (3), .H_BP (3),
        .V_ACTIVE (4), .V_FP (1), .V_SYNC (2), .V_BP (1), .SYNC_POL (1'b1)
    ) u_pol (
        .clk (clk), .rst (rst2), .pll_locked (lock2),
        .pix_data (24'h123456), .pix_empty (1'b0), .pix_rd (pix_rd2),
        .hsync (hsync2), .vsync (vsync2), .de (de2), .x (x2), .y (y2), .rgb (rgb2),
        .frame_start (fs2), .underflow (uf2), .underflow_clr (1'b0)
    );

    // Upstream show-ahead FIFO: head word is a known function of how many were popped.
    assign pix_data = pixval(word_idx);
    always @(posedge clk or posedge rst) begin
        if (rst) word_idx <= 0;
        else if (pix_rd) word_idx <= word_idx + 1;
    end

    // Model: lock_s is pll_locked two edges late, RUN one edge after that; raster
    // position is the cycle count since entering RUN.
    logic p0, p1, p2;
    int ph;
    logic o_run, o_act, o_hs, o_vs, o_pop, m_uf;
    int o_h, o_v, o_word, m_pops;

    always @(negedge clk) begin : model_cmp
        logic r0, a0, hs0, vs0;
        int h, v;
        if (rst) begin
            p0 <= 1'b0; p1 <= 1'b0; p2 <= 1'b0; ph <= 0;
            o_run <= 1'b0; o_act <= 1'b0; o_hs <= 1'b0; o_vs <= 1'b0; o_pop <= 1'b0;
            o_h <= 0; o_v <= 0; o_word <= 0; m_pops <= 0; m_uf <= 1'b0;
        end else begin
            r0  = p2 && p1;
            h   = ph % HT;
            v   = (ph / HT) % VT;
            a0  = r0 && (h < HA) && (v < VA);
            hs0 = (h >= 656) && (h < 752);
            vs0 = (v >= VA + VF) && (v < VA + VF + VS);
            if (cmp_on) begin
                chk("pix_rd", pix_rd, a0 && !pix_empty);
                chk("de", de, o_act);
                chk("hsync", hsync, !(o_run && o_hs));
                chk("vsync", vsync, !(o_run && o_vs));
                chk("x", x, o_run ? o_h : 0);
                chk("y", y, o_run ? o_v : 0);
                chk("frame_start", frame_start, o_run && o_h == 0 && o_v == 0);
                chk("rgb", rgb, o_pop ? pixval(o_word) : 24'h0);
                chk("underflow", underflow, m_uf);
            end
            p2 <= p1; p1 <= p0; p0 <= pll_locked;
            ph <= r0 ? ph + 1 : 0;
            o_run <= r0; o_act <= a0; o_hs <= hs0; o_vs <= vs0; o_h <= h; o_v <= v;
            o_pop <= a0 && !pix_empty;
            o_word <= m_pops;
            if (a0 && !pix_empty) m_pops <= m_pops + 1;
            if (a0 && pix_empty) m_uf <= 1'b1;
            else if (underflow_clr) m_uf <= 1'b0;
        end
    end

    initial begin
        #(70000 * 40);
        $display("FAIL watchdog: time limit reached, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    int de_l0, hs_first, hs_cnt0, de_rise2, vs_first, vs_cnt, fs_cnt, pops, guard;
    logic prev_de;

    initial begin
        rst = 1'b1; pll_locked = 1'b0; pix_empty = 1'b0; underflow_clr = 1'b0;
        rst2 = 1'b1; lock2 = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("rst_hsync", hsync, 1); chk("rst_vsync", vsync, 1); chk("rst_de", de, 0);
        chk("rst_pix_rd", pix_rd, 0); chk("rst_fs", frame_start, 0); chk("rst_uf", underflow, 0);
        chk("rst_x", x, 0); chk("rst_y", y, 0); chk("rst_rgb", rgb, 0);
        rst = 1'b0;
        cmp_on = 1'b1;

        @(posedge clk); #1;
        pll_locked = 1'b1;
        repeat (3) @(posedge clk); #1;
        chk("lock_de_edge3", de, 0);
        @(posedge clk); #1;
        chk("lock_de_edge4", de, 1); chk("lock_fs_edge4", frame_start, 1);
        chk("lock_x", x, 0); chk("lock_y", y, 0); chk("first_rgb", rgb, 24'h000003);

        de_l0 = 0; hs_first = -1; hs_cnt0 = 0; de_rise2 = -1;
        vs_first = -1; vs_cnt = 0; fs_cnt = 0; pops = 0; prev_de = 1'b1;
        for (int t = 0; t < HT * VT; t++) begin
            @(negedge clk);
            if (t == 1) chk("second_rgb", rgb, 24'h00000a);
            if (t < HT && de) de_l0++;
            if (t < HT && !hsync) hs_cnt0++;
            if (!hsync && hs_first < 0) hs_first = t;
            if (t > 0 && de && !prev_de && de_rise2 < 0) de_rise2 = t;
            if (!vsync) begin
                if (vs_first < 0) vs_first = t;
                vs_cnt++;
            end
            if (t > 0 && frame_start) fs_cnt++;
            if (pix_rd) pops++;
            prev_de = de;
        end
        chk("de_per_line", de_l0, 640); chk("hsync_start", hs_first, 656);
        chk("hsync_width", hs_cnt0, 96); chk("line_period", de_rise2, 800);
        chk("vsync_start", vs_first, 23 * 800); chk("vsync_width", vs_cnt, 2 * 800);
        chk("fs_in_frame", fs_cnt, 0); chk("pops_per_frame", pops, 640 * VA);
        @(negedge clk);
        chk("frame_period", frame_start, 1);

        repeat (1699) @(posedge clk); #1;
        pix_empty = 1'b1;
        #1;
        chk("uf_no_pop", pix_rd, 0);
        @(posedge clk); #1;
        chk("uf_x", x, 100); chk("uf_y", y, 2); chk("uf_de", de, 1);
        chk("uf_rgb", rgb, 0); chk("uf_set", underflow, 1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        pix_empty = 1'b0;
        repeat (50) @(posedge clk); #1;
        chk("uf_sticky", underflow, 1);
        underflow_clr = 1'b1;
        @(posedge clk); #1;
        underflow_clr = 1'b0;
        chk("uf_clr", underflow, 0);
        pix_empty = 1'b1; underflow_clr = 1'b1;
        @(posedge clk); #1;
        pix_empty = 1'b0; underflow_clr = 1'b0;
        chk("uf_set_wins", underflow, 1);
        underflow_clr = 1'b1;
        @(posedge clk); #1;
        underflow_clr = 1'b0;
        chk("uf_clr2", underflow, 0);

        guard = 0;
        while (ph != HT * VT + 15 * HT + 300 && guard < 30000) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("reach_line15", guard < 30000, 1);
        pll_locked = 1'b0;
        repeat (2) @(posedge clk); #1;
        chk("loss_pix_rd", pix_rd, 0);
        @(posedge clk); #1;
        chk("loss_de", de, 0); chk("loss_hsync", hsync, 1); chk("loss_x", x, 0);
        repeat (10) @(posedge clk); #1;
        pll_locked = 1'b1;
        repeat (4) @(posedge clk); #1;
        chk("relock_fs", frame_start, 1); chk("relock_de", de, 1);
        chk("relock_x", x, 0); chk("relock_y", y, 0);
        repeat (3) @(posedge clk); #1;
        chk("relock_x3", x, 3);

        chk("pol_rst_hsync", hsync2, 0); chk("pol_rst_vsync", vsync2, 0);
        rst2 = 1'b0;
        @(posedge clk); #1;
        lock2 = 1'b1;
        repeat (4) @(posedge clk); #1;
        chk("pol_fs", fs2, 1); chk("pol_hsync_idle", hsync2, 0);
        hs_first = -1; hs_cnt0 = 0; vs_first = -1; vs_cnt = 0;
        for (int t = 0; t < 128; t++) begin
            @(negedge clk);
            if (t < 16 && hsync2) hs_cnt0++;
            if (hsync2 && hs_first < 0) hs_first = t;
            if (vsync2) begin
                if (vs_first < 0) vs_first = t;
                vs_cnt++;
            end
        end
        chk("pol_hs_start", hs_first, 10); chk("pol_hs_width", hs_cnt0, 3);
        chk("pol_vs_start", vs_first, 80); chk("pol_vs_width", vs_cnt, 32);
        @(posedge clk); #5;
        chk("pol_de_midline", de2, 1);
        rst2 = 1'b1;
        #1;
        chk("arst_de", de2, 0); chk("arst_hsync", hsync2, 0); chk("arst_vsync", vsync2, 0);
        chk("arst_x", x2, 0); chk("arst_y", y2, 0); chk("arst_rgb", rgb2, 0);
        chk("arst_fs", fs2, 0); chk("arst_pix_rd", pix_rd2, 0); chk("arst_uf", uf2, 0);

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
